// File: rtl/alu_mdu.sv
// Execute-stage ALU for the MIPS datapath. Results are registered, and an iterative
// multiply/divide unit writes HI/LO after WIDTH cycles; busy stalls the pipeline meanwhile.
module alu_mdu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ovf,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int unsigned      W2       = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_MULT  = 4'b1001;
   localparam logic [3:0] OP_MULTU = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
   localparam logic [3:0] OP_MFLO  = 4'b1110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic             accept, go_mul, go_div, fin_mul, fin_div, last_iter;
   logic             is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] sum, dif, alu_y;
   logic             alu_ovf;

   logic [W2-1:0]    acc_q;
   logic [WIDTH-1:0] opnd_q, a_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q, rneg_q, dz_q;

   logic [WIDTH:0]   mul_add;
   logic [W2-1:0]    mul_next, mul_prod;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [W2-1:0]    div_next;
   logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign last_iter = (cnt_q == CNT_LAST);

   // Next state and control strobes; requests are only taken in IDLE
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      go_mul  = 1'b0;
      go_div  = 1'b0;
      fin_mul = 1'b0;
      fin_div = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if ((op == OP_MULT) || (op == OP_MULTU)) begin
                  go_mul  = 1'b1;
                  state_d = S_MUL;
               end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                  go_div  = 1'b1;
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (last_iter) begin
               fin_mul = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DIV: begin
            if (last_iter) begin
               fin_div = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sum = a + b;
   assign dif = a - b;

   // Single-cycle result
   always_comb begin
      alu_y   = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND:  alu_y = a & b;
         OP_OR:   alu_y = a | b;
         OP_ADD: begin
            alu_y   = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:  alu_y = a ^ b;
         OP_NOR:  alu_y = ~(a | b);
         OP_SUB: begin
            alu_y   = dif;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MFHI: alu_y = hi;
         OP_MFLO: alu_y = lo;
         default: alu_y = '0;
      endcase
   end

   // Signed mul/div runs on magnitudes; signs are fixed up at completion
   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg     = is_signed & a[WIDTH-1];
   assign b_neg     = is_signed & b[WIDTH-1];
   assign mag_a     = a_neg ? (~a + WIDTH'(1)) : a;
   assign mag_b     = b_neg ? (~b + WIDTH'(1)) : b;

   // Shift-add step: acc holds {partial product, remaining multiplier bits}
   assign mul_add  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_add, acc_q[WIDTH-1:1]};
   assign mul_prod = neg_q ? (~mul_next + W2'(1)) : mul_next;

   // Restoring step: acc holds {partial remainder, dividend/quotient bits}
   assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge   = (rem_sh >= {1'b0, opnd_q});
   assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;
   assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   assign quo      = div_next[WIDTH-1:0];
   assign rem      = div_next[W2-1:WIDTH];
   assign quo_fix  = neg_q  ? (~quo + WIDTH'(1)) : quo;
   assign rem_fix  = rneg_q ? (~rem + WIDTH'(1)) : rem;

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y      <= '0;
         zero   <= 1'b1;
         ovf    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
         acc_q  <= '0;
         opnd_q <= '0;
         a_q    <= '0;
         cnt_q  <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (go_mul) begin
            busy   <= 1'b1;
            div0   <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= mag_a;
            acc_q  <= {{WIDTH{1'b0}}, mag_b};
            neg_q  <= a_neg ^ b_neg;
         end else if (go_div) begin
            busy   <= 1'b1;
            div0   <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= mag_b;
            acc_q  <= {{WIDTH{1'b0}}, mag_a};
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= (b == '0);
            a_q    <= a;
         end else if (accept) begin
            y    <= alu_y;
            zero <= (alu_y == '0);
            ovf  <= alu_ovf;
            done <= 1'b1;
         end

         case (state_q)
            S_MUL: begin
               acc_q <= mul_next;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            S_DIV: begin
               acc_q <= div_next;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase

         if (fin_mul) begin
            {hi, lo} <= mul_prod;
            busy     <= 1'b0;
            done     <= 1'b1;
         end
         if (fin_div) begin
            busy <= 1'b0;
            done <= 1'b1;
            // Divide by zero yields the raw restoring-division result shape
            if (dz_q) begin
               lo   <= '1;
               hi   <= a_q;
               div0 <= 1'b1;
            end else begin
               lo <= quo_fix;
               hi <= rem_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: a driver pushes expected results from a 64-bit
// arithmetic reference model, and a monitor pops and compares on every done pulse.
module tb_alu_mdu;

   localparam int unsigned W = 32;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_NOP5  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_MULT  = 4'b1001;
   localparam logic [3:0] OP_MULTU = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
   localparam logic [3:0] OP_MFLO  = 4'b1110;
   localparam logic [3:0] OP_NOPF  = 4'b1111;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a, b, y, hi, lo;
   logic         zero, ovf, busy, done, div0;

   alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .y     (y),
      .zero  (zero),
      .ovf   (ovf),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done),
      .div0  (div0)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] y;
      logic         zero;
      logic         ovf;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Architectural state as the reference model sees it
   logic [W-1:0] m_y    = '0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;
   logic         m_zero = 1'b1;
   logic         m_ovf  = 1'b0;
   logic         m_div0 = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_done: done=1 with no pending op (y=0x%0h), expected done=0", y);
         end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("y op=%0h", mon_e.op), 64'(y), 64'(mon_e.y));
            check($sformatf("zero op=%0h", mon_e.op), 64'(zero), 64'(mon_e.zero));
            check($sformatf("ovf op=%0h", mon_e.op), 64'(ovf), 64'(mon_e.ovf));
            check($sformatf("hi op=%0h", mon_e.op), 64'(hi), 64'(mon_e.hi));
            check($sformatf("lo op=%0h", mon_e.op), 64'(lo), 64'(mon_e.lo));
            check($sformatf("div0 op=%0h", mon_e.op), 64'(div0), 64'(mon_e.div0));
         end
      end
   end

   task automatic reset_values(input string tag);
      check({tag, "_y"},    64'(y),    64'd0);
      check({tag, "_zero"}, 64'(zero), 64'd1);
      check({tag, "_ovf"},  64'(ovf),  64'd0);
      check({tag, "_hi"},   64'(hi),   64'd0);
      check({tag, "_lo"},   64'(lo),   64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_div0"}, 64'(div0), 64'd0);
   endtask

   task automatic model_reset();
      m_y = '0; m_hi = '0; m_lo = '0; m_zero = 1'b1; m_ovf = 1'b0; m_div0 = 1'b0;
   endtask

   // Issue one op once idle; optionally poke an ADD start mid-flight, which must be ignored
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                        input bit intrude);
      int                guard;
      int                lat;
      bit                long_op;
      longint            sx, sz, r, q;
      longint unsigned   ux, uz, p, uq, ur;
      exp_t              e;
      guard = 0;
      while (busy !== 1'b0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("idle_before_issue", 64'(busy), 64'd0);

      sx = longint'($signed(x));
      sz = longint'($signed(z));
      ux = 64'(x);
      uz = 64'(z);
      long_op = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
      if (!long_op) m_ovf = 1'b0;
      case (o)
         OP_AND:  m_y = x & z;
         OP_OR:   m_y = x | z;
         OP_XOR:  m_y = x ^ z;
         OP_NOR:  m_y = ~(x | z);
         OP_ADD: begin
            r = sx + sz;
            m_y = r[31:0];
            m_ovf = (r > SMAX) || (r < SMIN);
         end
         OP_SUB: begin
            r = sx - sz;
            m_y = r[31:0];
            m_ovf = (r > SMAX) || (r < SMIN);
         end
         OP_SLT:  m_y = (sx < sz) ? 32'd1 : 32'd0;
         OP_SLTU: m_y = (ux < uz) ? 32'd1 : 32'd0;
         OP_MFHI: m_y = m_hi;
         OP_MFLO: m_y = m_lo;
         OP_MULT: begin
            r = sx * sz;
            {m_hi, m_lo} = 64'(r);
            m_div0 = 1'b0;
         end
         OP_MULTU: begin
            p = ux * uz;
            {m_hi, m_lo} = p;
            m_div0 = 1'b0;
         end
         OP_DIV: begin
            if (z == '0) begin
               m_lo = '1; m_hi = x; m_div0 = 1'b1;
            end else begin
               q = sx / sz;
               r = sx % sz;
               m_lo = q[31:0]; m_hi = r[31:0]; m_div0 = 1'b0;
            end
         end
         OP_DIVU: begin
            if (z == '0) begin
               m_lo = '1; m_hi = x; m_div0 = 1'b1;
            end else begin
               uq = ux / uz;
               ur = ux % uz;
               m_lo = uq[31:0]; m_hi = ur[31:0]; m_div0 = 1'b0;
            end
         end
         default: m_y = '0;
      endcase
      if (!long_op) m_zero = (m_y == '0);
      e.op = o; e.y = m_y; e.zero = m_zero; e.ovf = m_ovf;
      e.hi = m_hi; e.lo = m_lo; e.div0 = m_div0;
      sb_q.push_back(e);

      start = 1'b1; op = o; a = x; b = z;
      @(posedge clk); #1;
      start = 1'b0;
      if (long_op) begin
         lat = 0;
         while (busy === 1'b1 && lat < 100) begin
            if (intrude && lat == 5) begin
               start = 1'b1; op = OP_ADD; a = 32'h1234; b = 32'h1;
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
         end
         start = 1'b0;
         check($sformatf("busy_cycles op=%0h", o), 64'(lat), 64'd32);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom());
      endcase
   endfunction

   logic [3:0] op_tab [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) op_tab[i] = 4'(i);
      rst_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_values("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Overflow, zero and compare cases
      issue(OP_ADD,  32'h7FFF_FFFF, 32'h1, 0);
      issue(OP_SUB,  32'd5, 32'd5, 0);
      issue(OP_SUB,  32'h8000_0000, 32'h1, 0);
      issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 0);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
      issue(OP_NOR,  32'h0, 32'h0, 0);
      issue(OP_NOP5, 32'h55, 32'h66, 0);
      issue(OP_NOPF, 32'h55, 32'h66, 0);

      // Multiply and HI/LO readback
      issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 0);
      issue(OP_MFHI,  32'h0, 32'h0, 0);
      issue(OP_MFLO,  32'h0, 32'h0, 0);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(OP_MFHI,  32'h0, 32'h0, 0);
      issue(OP_MFLO,  32'h0, 32'h0, 0);

      // Divide corner cases
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
      issue(OP_DIVU,  32'd7, 32'd0, 0);
      issue(OP_MULTU, 32'd3, 32'd4, 0);
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd0, 0);

      // Ignored start while busy, then back-to-back acceptance in the done cycle
      issue(OP_MULT, 32'h0001_0003, 32'hFFFF_0005, 1);
      issue(OP_DIVU, 32'd1000, 32'd7, 0);
      check("done_at_b2b_issue", 64'(done), 64'd1);
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      check("done_at_b2b_issue2", 64'(done), 64'd1);
      issue(OP_ADD, 32'd1, 32'd2, 0);

      // Randomised traffic
      for (int n = 0; n < 200; n++) begin
         issue(op_tab[$urandom_range(0, 15)], pick(), pick(), ($urandom_range(0, 7) == 0));
      end

      // Reset in the middle of a divide aborts it
      while (busy !== 1'b0) begin @(posedge clk); #1; end
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      reset_values("abort");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      issue(OP_MFHI, 32'h0, 32'h0, 0);
      issue(OP_MFLO, 32'h0, 32'h0, 0);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor of the single-cycle MIPS ALU.
- Adds registered outputs, a start/busy/done handshake, and an iterative multiply/divide unit with HI/LO registers.
- Sits in the execute stage of the MIPS datapath.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32: operand, result, HI and LO width (minimum 8).
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  op request, sampled on rising edge.
- op  in  4  operation code.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt/imm).
- y  out  WIDTH  registered result.
- zero  out  1  registered, (y == 0).
- ovf  out  1  registered signed overflow (ADD/SUB only, else 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multiply/divide in progress.
- done  out  1  one-cycle pulse when the result is valid.
- div0  out  1  sticky divide-by-zero flag of the last DIV/DIVU; cleared by the next accepted MULT/MULTU/DIV/DIVU.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB.
  - 0111 SLT (signed), 1000 SLTU.
  - 1001 MULT, 1010 MULTU, 1011 DIV, 1100 DIVU.
  - 1101 MFHI, 1110 MFLO.
  - 0101 and 1111: y=0, done pulses, no other effect.
- Reset (reset=0, async): y=0, zero=1, ovf=0, hi=0, lo=0, busy=0, done=0, div0=0, FSM=IDLE, counter=0. Reset during MUL/DIV aborts with no HI/LO update.
- Accept: start=1 and busy=0 at edge E. start while busy=1 is ignored; no queueing.
- Single-cycle ops (all except MULT/MULTU/DIV/DIVU):
  - y, zero, ovf registered at E; done=1 for the cycle after E.
  - Arithmetic wraps modulo 2^WIDTH.
  - ovf for ADD: signs of a and b equal and differ from the sign of the sum. For SUB: signs of a and b differ and the result sign differs from a.
  - SLT/SLTU: y = {0..0, lt}.
  - MFHI/MFLO read HI/LO as they stand at E.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted MULT/MULTU; IDLE -> DIV on accepted DIV/DIVU.
  - At E: operands latched, busy=1, counter=0, y unchanged.
- MUL: shift-add, one bit per cycle for WIDTH cycles (edges E+1..E+WIDTH).
  - Signed: multiply magnitudes; negate the 2*WIDTH product if the signs differ.
  - At E+WIDTH: {hi,lo} = product, busy=0, done=1 next cycle, FSM -> IDLE.
- DIV: restoring division on magnitudes, WIDTH cycles.
  - At E+WIDTH: lo = quotient, hi = remainder.
  - Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Signed MIN / -1: lo = MIN, hi = 0 (wraps, no flag).
  - b = 0: no iteration fault. At E+WIDTH, lo = all ones, hi = a, div0 = 1.
- MUL/DIV latency: exactly WIDTH cycles from accept to busy falling. done pulses in the same cycle busy is first 0.
- A start accepted in the cycle done is high is legal; the next op runs back-to-back.
- zero/ovf are unaffected by MUL/DIV completion.
- MFHI/MFLO issued while busy are ignored (start ignored); control must wait for busy=0.

Test Plan (WIDTH=32):
1. ADD a=0x7FFFFFFF, b=1 -> next cycle y=0x80000000, ovf=1, zero=0, done=1. SUB a=5, b=5 -> y=0, zero=1, ovf=0.
2. SLT a=0xFFFFFFFF, b=1 -> y=1; SLTU with the same operands -> y=0. NOR a=0, b=0 -> y=0xFFFFFFFF.
3. MULT a=-3, b=7 -> busy high for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Follow with MFHI/MFLO -> y matches.
4. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div0=1. Next MULTU clears div0. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
5. While busy, pulse start with ADD -> ignored: y unchanged, no extra done. Start accepted in the done cycle -> runs back-to-back.
6. Assert reset at cycle 10 of a DIV -> all outputs to reset values immediately (async). HI/LO stay 0; no done after release.
